// File: rtl/gemm_pkg.sv
// Shared definitions for the 2x2 GEMM feed controller: FSM encoding and lane count.
package gemm_pkg;

    localparam int LANES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/gemm_operand_store.sv
// A-column and B-row operand register files: one write port, and two combinational
// read ports returning lane 0 of entry t and lane 1 of entry t-1 (out-of-range reads give 0).
module gemm_operand_store #(
    parameter int OP_WIDTH = 8,
    parameter int K_MAX    = 8,
    parameter int IW       = 3,
    parameter int AW       = 4
) (
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic                    i_wr_sel,
    input  logic [IW-1:0]           i_wr_idx,
    input  logic [2*OP_WIDTH-1:0]   i_wr_data,
    input  logic [AW-1:0]           i_rd_idx_t,
    input  logic [AW-1:0]           i_rd_idx_tm1,
    output logic [OP_WIDTH-1:0]     o_a_t_lane0,
    output logic [OP_WIDTH-1:0]     o_b_t_lane0,
    output logic [OP_WIDTH-1:0]     o_a_tm1_lane1,
    output logic [OP_WIDTH-1:0]     o_b_tm1_lane1
);

    localparam int DW = 2 * OP_WIDTH;
    localparam logic [AW-1:0] K_LIMIT = AW'(K_MAX);

    logic [DW-1:0] r_a_mem [K_MAX];
    logic [DW-1:0] r_b_mem [K_MAX];

    // Write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            if (i_wr_sel) begin
                r_b_mem[i_wr_idx] <= i_wr_data;
            end else begin
                r_a_mem[i_wr_idx] <= i_wr_data;
            end
        end
    end

    // Read port at index t, lane 0.
    always_comb begin
        o_a_t_lane0 = {OP_WIDTH{1'b0}};
        o_b_t_lane0 = {OP_WIDTH{1'b0}};
        if (i_rd_idx_t < K_LIMIT) begin
            o_a_t_lane0 = r_a_mem[i_rd_idx_t[IW-1:0]][OP_WIDTH-1:0];
            o_b_t_lane0 = r_b_mem[i_rd_idx_t[IW-1:0]][OP_WIDTH-1:0];
        end else begin
            o_a_t_lane0 = {OP_WIDTH{1'b0}};
            o_b_t_lane0 = {OP_WIDTH{1'b0}};
        end
    end

    // Read port at index t-1, lane 1.
    always_comb begin
        o_a_tm1_lane1 = {OP_WIDTH{1'b0}};
        o_b_tm1_lane1 = {OP_WIDTH{1'b0}};
        if (i_rd_idx_tm1 < K_LIMIT) begin
            o_a_tm1_lane1 = r_a_mem[i_rd_idx_tm1[IW-1:0]][DW-1:OP_WIDTH];
            o_b_tm1_lane1 = r_b_mem[i_rd_idx_tm1[IW-1:0]][DW-1:OP_WIDTH];
        end else begin
            o_a_tm1_lane1 = {OP_WIDTH{1'b0}};
            o_b_tm1_lane1 = {OP_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/gemm_feed_controller.sv
// Feeds one 2x2 GEMM tile: streams k_len A columns / B rows with a one-cycle lane skew,
// then drains and pulses done. All outputs are registered.
module gemm_feed_controller
    import gemm_pkg::*;
#(
    parameter int OP_WIDTH     = 8,
    parameter int K_MAX        = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic                          wr_sel,
    input  logic [$clog2(K_MAX)-1:0]      wr_idx,
    input  logic [LANES*OP_WIDTH-1:0]     wr_data,
    input  logic                          start,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          acc_clear,
    output logic [LANES*OP_WIDTH-1:0]     new_a_column,
    output logic [LANES*OP_WIDTH-1:0]     new_b_row,
    output logic [LANES-1:0]              new_a_column_ena,
    output logic [LANES-1:0]              new_b_row_ena
);

    localparam int IW = $clog2(K_MAX);
    localparam int AW = $clog2(K_MAX + 1);
    localparam int DW = LANES * OP_WIDTH;
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [AW-1:0] K_LIMIT    = AW'(K_MAX);
    localparam logic [AW-1:0] ONE_A      = AW'(1);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [AW-1:0]       r_k_len;
    logic [AW-1:0]       r_t;
    logic [AW-1:0]       w_t_next;
    logic [AW-1:0]       w_tm1_next;
    logic [CW-1:0]       r_d;
    logic                w_idle;
    logic                w_start_ok;
    logic                w_start_zero;
    logic                w_start_bad;
    logic                w_feed_last;
    logic                w_drain_last;
    logic [OP_WIDTH-1:0] w_a_t_lane0;
    logic [OP_WIDTH-1:0] w_b_t_lane0;
    logic [OP_WIDTH-1:0] w_a_tm1_lane1;
    logic [OP_WIDTH-1:0] w_b_tm1_lane1;
    logic [OP_WIDTH-1:0] r_a_lane0;
    logic [OP_WIDTH-1:0] r_b_lane0;
    logic [OP_WIDTH-1:0] r_a_lane1;
    logic [OP_WIDTH-1:0] r_b_lane1;
    logic                w_ena0;
    logic                w_ena1;
    logic                w_acc_clear;
    logic [DW-1:0]       w_a_out;
    logic [DW-1:0]       w_b_out;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_start_bad  = w_idle && start && (k_len > K_LIMIT);
    assign w_start_zero = w_idle && start && (k_len == {AW{1'b0}});
    assign w_start_ok   = w_idle && start && !w_start_bad && !w_start_zero;
    assign w_feed_last  = (r_t == r_k_len);
    assign w_drain_last = (r_d == DRAIN_LAST);

    // Read addresses look one cycle ahead so the operand is staged at the edge that sets t;
    // address K_MAX is used as an "empty" index that reads back zero.
    assign w_t_next   = ((r_state == ST_FEED) && !w_feed_last) ? (r_t + ONE_A) : {AW{1'b0}};
    assign w_tm1_next = (w_t_next == {AW{1'b0}}) ? K_LIMIT : (w_t_next - ONE_A);

    gemm_operand_store #(
        .OP_WIDTH (OP_WIDTH),
        .K_MAX    (K_MAX),
        .IW       (IW),
        .AW       (AW)
    ) u_store (
        .clk           (clk),
        .i_wr_en       (wr_en && w_idle),
        .i_wr_sel      (wr_sel),
        .i_wr_idx      (wr_idx),
        .i_wr_data     (wr_data),
        .i_rd_idx_t    (w_t_next),
        .i_rd_idx_tm1  (w_tm1_next),
        .o_a_t_lane0   (w_a_t_lane0),
        .o_b_t_lane0   (w_b_t_lane0),
        .o_a_tm1_lane1 (w_a_tm1_lane1),
        .o_b_tm1_lane1 (w_b_tm1_lane1)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = ST_FEED;
                end else if (w_start_zero) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FEED:  w_state_next = w_feed_last  ? ST_DRAIN : ST_FEED;
            ST_DRAIN: w_state_next = w_drain_last ? ST_DONE  : ST_DRAIN;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Feed/drain counters, latched run length and staged operand lanes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_t       <= {AW{1'b0}};
            r_d       <= {CW{1'b0}};
            r_k_len   <= {AW{1'b0}};
            r_a_lane0 <= {OP_WIDTH{1'b0}};
            r_b_lane0 <= {OP_WIDTH{1'b0}};
            r_a_lane1 <= {OP_WIDTH{1'b0}};
            r_b_lane1 <= {OP_WIDTH{1'b0}};
        end else begin
            r_t       <= w_t_next;
            r_d       <= ((r_state == ST_DRAIN) && !w_drain_last) ? (r_d + ONE_C) : {CW{1'b0}};
            r_a_lane0 <= w_a_t_lane0;
            r_b_lane0 <= w_b_t_lane0;
            r_a_lane1 <= w_a_tm1_lane1;
            r_b_lane1 <= w_b_tm1_lane1;
            if (w_start_ok) begin
                r_k_len <= k_len;
            end
        end
    end

    // FSM output decode: lane 1 trails lane 0 by one cycle; disabled lanes carry zero.
    always_comb begin
        w_ena0      = 1'b0;
        w_ena1      = 1'b0;
        w_acc_clear = 1'b0;
        w_a_out     = {DW{1'b0}};
        w_b_out     = {DW{1'b0}};
        if (r_state == ST_FEED) begin
            w_ena0      = (r_t < r_k_len);
            w_ena1      = (r_t != {AW{1'b0}});
            w_acc_clear = (r_t == {AW{1'b0}});
        end else begin
            w_ena0      = 1'b0;
            w_ena1      = 1'b0;
            w_acc_clear = 1'b0;
        end
        if (w_ena0) begin
            w_a_out[OP_WIDTH-1:0] = r_a_lane0;
            w_b_out[OP_WIDTH-1:0] = r_b_lane0;
        end else begin
            w_a_out[OP_WIDTH-1:0] = {OP_WIDTH{1'b0}};
            w_b_out[OP_WIDTH-1:0] = {OP_WIDTH{1'b0}};
        end
        if (w_ena1) begin
            w_a_out[DW-1:OP_WIDTH] = r_a_lane1;
            w_b_out[DW-1:OP_WIDTH] = r_b_lane1;
        end else begin
            w_a_out[DW-1:OP_WIDTH] = {OP_WIDTH{1'b0}};
            w_b_out[DW-1:OP_WIDTH] = {OP_WIDTH{1'b0}};
        end
    end

    // Output registers; busy tracks the upcoming state so it falls as done rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            acc_clear        <= 1'b0;
            new_a_column     <= {DW{1'b0}};
            new_b_row        <= {DW{1'b0}};
            new_a_column_ena <= {LANES{1'b0}};
            new_b_row_ena    <= {LANES{1'b0}};
        end else begin
            busy             <= (w_state_next != ST_IDLE);
            done             <= (r_state == ST_DONE);
            err              <= w_start_bad;
            acc_clear        <= w_acc_clear;
            new_a_column     <= w_a_out;
            new_b_row        <= w_b_out;
            new_a_column_ena <= {w_ena1, w_ena0};
            new_b_row_ena    <= {w_ena1, w_ena0};
        end
    end

endmodule

// File: tb/tb_gemm_feed_controller.sv
// Directed bench for gemm_feed_controller: operand store holds A[k]={k+11,k+1},
// B[k]={k+31,k+21}; each run is compared cycle by cycle against the expected stream.
module tb_gemm_feed_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [2:0]  wr_idx = 3'd0;
    logic [15:0] wr_data = 16'd0;
    logic        start = 1'b0;
    logic [3:0]  k_len = 4'd0;
    logic        busy, done, err, acc_clear;
    logic [15:0] new_a_column, new_b_row;
    logic [1:0]  new_a_column_ena, new_b_row_ena;
    logic [7:0]  ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    gemm_feed_controller dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (wr_en),
        .wr_sel           (wr_sel),
        .wr_idx           (wr_idx),
        .wr_data          (wr_data),
        .start            (start),
        .k_len            (k_len),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .acc_clear        (acc_clear),
        .new_a_column     (new_a_column),
        .new_b_row        (new_b_row),
        .new_a_column_ena (new_a_column_ena),
        .new_b_row_ena    (new_b_row_ena)
    );

    always #5 clk = ~clk;

    assign ctrl = {busy, done, err, acc_clear, new_a_column_ena, new_b_row_ena};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_sample(input string tag, input int s, input logic [39:0] e);
        check_eq($sformatf("%s_ctrl_s%0d", tag, s), {24'd0, ctrl}, {24'd0, e[39:32]});
        check_eq($sformatf("%s_a_s%0d", tag, s), {16'd0, new_a_column}, {16'd0, e[31:16]});
        check_eq($sformatf("%s_b_s%0d", tag, s), {16'd0, new_b_row}, {16'd0, e[15:0]});
    endtask

    // Expected {ctrl, a, b} at sample s (s=0 is the cycle right after the accepted start).
    function automatic logic [39:0] expect_at(input int k, input int s);
        logic [7:0]  c;
        logic [15:0] a;
        logic [15:0] b;
        int          t;
        bit          feed, e0, e1;
        c = 8'h00;
        a = 16'h0000;
        b = 16'h0000;
        t = s - 1;
        if (k == 0) begin
            c = (s == 0) ? 8'h80 : ((s == 1) ? 8'h40 : 8'h00);
        end else begin
            feed = (s >= 1) && (s <= k + 1);
            e0   = feed && (t < k);
            e1   = feed && (t >= 1);
            c    = {(s <= k + 4), (s == k + 5), 1'b0, (feed && t == 0), e1, e0, e1, e0};
            if (e0) begin
                a[7:0] = 8'(t + 1);
                b[7:0] = 8'(t + 21);
            end
            if (e1) begin
                a[15:8] = 8'(t + 10);
                b[15:8] = 8'(t + 30);
            end
        end
        return {c, a, b};
    endfunction

    task automatic run(input string tag, input int k, input bit disturb);
        @(negedge clk);
        start = 1'b1;
        k_len = 4'(k);
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < k + 7; s++) begin
            check_sample(tag, s, expect_at(k, s));
            if (disturb && s == 2) begin
                start   = 1'b1;
                k_len   = 4'd2;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_idx  = 3'd2;
                wr_data = 16'hFFFF;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        check_sample("reset", 0, 40'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 3'(i); wr_data = {8'(i + 11), 8'(i + 1)};
            @(negedge clk);
            wr_sel = 1'b1; wr_data = {8'(i + 31), 8'(i + 21)};
        end
        @(negedge clk);
        wr_en = 1'b0;

        run("k3", 3, 1'b0);
        run("k0", 0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        k_len = 4'd9;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            check_eq($sformatf("k9_ctrl_s%0d", s), {24'd0, ctrl}, (s == 0) ? 32'h20 : 32'h00);
            @(negedge clk);
        end

        run("k3_disturbed", 3, 1'b1);
        run("k3_after", 3, 1'b0);

        @(negedge clk);
        start = 1'b1;
        k_len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_sample("pre_reset", 2, expect_at(3, 2));
        #3;
        reset = 1'b1;
        #1;
        check_sample("mid_reset", 0, 40'd0);
        @(negedge clk);
        reset = 1'b0;
        run("k2_post_reset", 2, 1'b0);

        run("k8", 8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gemm_feed_controller.md
GEMM_FEED_CONTROLLER -- requirements
Module: gemm_feed_controller

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 8, giving the operand width in bits.
REQ-002 SHALL have parameter K_MAX, default 8, giving the maximum inner dimension (depth of the operand store).
REQ-003 SHALL have parameter DRAIN_CYCLES, default 3, giving the idle cycles after the last feed before done.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1 bit: write the operand store.
REQ-007 SHALL have port wr_sel, input, 1 bit: 0 selects A-column store, 1 selects B-row store.
REQ-008 SHALL have port wr_idx, input, clog2(K_MAX) bits: k index to write.
REQ-009 SHALL have port wr_data, input, 2*OP_WIDTH bits: lane i in bits [i*OP_WIDTH +: OP_WIDTH].
REQ-010 SHALL have port start, input, 1 bit: single-cycle request to run one 2x2 tile.
REQ-011 SHALL have port k_len, input, clog2(K_MAX+1) bits: inner dimension, sampled with start.
REQ-012 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse when start is rejected for k_len > K_MAX.
REQ-015 SHALL have port acc_clear, output, 1 bit: one-cycle pulse on the first FEED cycle.
REQ-016 SHALL have ports new_a_column / new_b_row, output, 2*OP_WIDTH bits each: skewed operand lanes to the input manager.
REQ-017 SHALL have ports new_a_column_ena / new_b_row_ena, output, 2 bits each: per-lane valid.

Function
REQ-018 SHALL implement FSM states IDLE, FEED, DRAIN, DONE; all outputs registered.
REQ-019 SHALL, in IDLE, on start with 1<=k_len<=K_MAX: latch k_len, clear cycle counter t, go to FEED.
REQ-020 SHALL, in IDLE, on start with k_len==0: go directly to DONE with no enables asserted.
REQ-021 SHALL, in IDLE, on start with k_len>K_MAX: pulse err next cycle and stay IDLE.
REQ-022 SHALL ignore start while not in IDLE.
REQ-023 SHALL hold FEED for exactly k_len+1 cycles, t = 0..k_len.
REQ-024 SHALL drive lane 0 at FEED cycle t with ena=1 and data A[t] / B[t] lane 0 iff t<k_len.
REQ-025 SHALL drive lane 1 at FEED cycle t with ena=1 and data A[t-1] / B[t-1] lane 1 iff 1<=t<=k_len, giving a one-cycle skew.
REQ-026 SHALL drive data bits of any lane to zero whenever that lane's ena is 0.
REQ-027 SHALL set A and B ena bits identically every cycle.
REQ-028 SHALL go to DRAIN after FEED, remain DRAIN_CYCLES cycles with all enables 0, then go to DONE.
REQ-029 SHALL pulse done for one cycle in DONE, drop busy in the same cycle, and return to IDLE.
REQ-030 SHALL apply writes only in IDLE; writes in any other state are dropped, so store contents are stable during a run.
REQ-031 SHALL give the same-cycle start and wr_en in IDLE: the write lands, and the run reads the new value only if index>0 (the index-0 read happens at the same edge and sees old data).
REQ-032 SHALL, on an accepted start at edge n, assert the first lane-0 enable after edge n+1.

Reset
REQ-033 SHALL, on reset, immediately force state IDLE, counters 0, and busy/done/err/acc_clear, all enables and data outputs to 0, including mid-run.
REQ-034 SHALL leave operand store contents unreset (undefined until written).

Structure
REQ-035 SHALL place FSM state encoding and the lane count constant (2) in shared package gemm_pkg.
REQ-036 SHALL implement the operand store as one sub-module, gemm_operand_store: two K_MAX x 2*OP_WIDTH register files, one write port, and two combinational read ports (t and t-1).

Verification
REQ-037 SHALL cover: K_MAX=8, load A[k]={k+1,k+11}, B[k]={k+21,k+31} for k=0..2; start k_len=3 -> lane0 ena 1,1,1,0; lane1 ena 0,1,1,1; lane1 data 11,12,13; then 3 idle cycles and a done pulse; busy high for 8 cycles.
REQ-038 SHALL cover: start k_len=0 -> done one cycle later, no enables, no acc_clear.
REQ-039 SHALL cover: start k_len=9 -> err pulse, busy stays 0, and no done.
REQ-040 SHALL cover: a second start and wr_en during FEED -> both ignored, and the output stream is identical to an undisturbed run.
REQ-041 SHALL cover: reset asserted mid-FEED between edges -> all outputs 0 without a clock edge, and a following start k_len=2 runs normally.
REQ-042 SHALL cover: k_len=K_MAX=8 -> 9 FEED cycles, and the lane-1 final data is A[7] lane 1.
